simon_core_param: RTL and testbench

- Parametrised Simon 2N/MN block-cipher encryption engine. Successor to the 32/64 nibble-serial core.
- Runs one round per clock, with the key schedule generated on the fly.
- Full-width valid/ready interfaces on input and output, with output backpressure.
- Sits between the host load/unload logic and the I/O wrapper. Encrypt only.

---
 rtl/simon_pkg.sv | 84 ++++++++
 rtl/simon_core_param_if.sv | 24 ++
 rtl/simon_key_sched.sv | 77 +++++++
 rtl/simon_core_param.sv | 103 ++++++++++
 tb/tb_simon_core_param.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared types, constants and helpers for the parametrised Simon 2N/MN encryption core.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } simon_state_e;

    typedef struct packed {
        int n;
        int m;
        int zseq;
        int t;
    } simon_cfg_t;

    // Published Simon design points with word size 16..32: 32/64, 48/72, 48/96, 64/96, 64/128.
    localparam simon_cfg_t STD_CFG [5] = '{
        '{n: 16, m: 4, zseq: 0, t: 32},
        '{n: 24, m: 3, zseq: 0, t: 36},
        '{n: 24, m: 4, zseq: 1, t: 36},
        '{n: 32, m: 3, zseq: 2, t: 42},
        '{n: 32, m: 4, zseq: 3, t: 44}
    };

    localparam int LEGAL_N [3] = '{16, 24, 32};
    localparam int LEGAL_M [3] = '{2, 3, 4};
    localparam int NUM_ZSEQ    = 5;

    function automatic logic [61:0] seqToBits(input logic [61:0] s);
        logic [61:0] r;
        for (int i = 0; i < 62; i++) r[i] = s[61 - i];
        return r;
    endfunction

    // Sequences are written leftmost-first as published; bit i ends up holding element i.
    localparam logic [61:0] Z0 = seqToBits(62'b11111010001001010110000111001101111101000100101011000011100110);
    localparam logic [61:0] Z1 = seqToBits(62'b10001110111110010011000010110101000111011111001001100001011010);
    localparam logic [61:0] Z2 = seqToBits(62'b10101111011100000011010010011000101000010001111110010110110011);
    localparam logic [61:0] Z3 = seqToBits(62'b11011011101011000110010111100000010010001010011100110100001111);
    localparam logic [61:0] Z4 = seqToBits(62'b11010001111001101011011000100000010111000011001010010011101111);

    function automatic logic [61:0] zConst(input int idx);
        logic [61:0] z;
        case (idx)
            0:       z = Z0;
            1:       z = Z1;
            2:       z = Z2;
            3:       z = Z3;
            default: z = Z4;
        endcase
        return z;
    endfunction

    function automatic bit cfgLegal(input int n, input int m, input int zs, input int t);
        bit nOk;
        bit mOk;
        nOk = 1'b0;
        mOk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (LEGAL_N[i] == n) nOk = 1'b1;
            if (LEGAL_M[i] == m) mOk = 1'b1;
        end
        return nOk && mOk && (zs >= 0) && (zs < NUM_ZSEQ) && (t >= m);
    endfunction

    // Rotations work on the low w bits of a 32-bit carrier so one helper serves every N.
    function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned s, input int unsigned w);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        v    = x & mask;
        return ((v << s) | (v >> (w - s))) & mask;
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned s, input int unsigned w);
        return rol(x, w - s, w);
    endfunction

    function automatic logic [31:0] simon_f(input logic [31:0] x, input int unsigned w);
        return (rol(x, 1, w) & rol(x, 8, w)) ^ rol(x, 2, w);
    endfunction

endpackage

// File: rtl/simon_core_param_if.sv
// Block-level valid/ready bus of the Simon core: key, plaintext in, ciphertext out.
interface simon_core_param_if #(
    parameter int N = 16,
    parameter int M = 4
);
    logic [M*N-1:0] i_key;
    logic           i_key_valid;
    logic [2*N-1:0] i_pt;
    logic           i_valid;
    logic           o_ready;
    logic [2*N-1:0] o_ct;
    logic           o_valid;
    logic           i_ready;

    modport slave (
        input  i_key, i_key_valid, i_pt, i_valid, i_ready,
        output o_ready, o_ct, o_valid
    );

    modport master (
        output i_key, i_key_valid, i_pt, i_valid, i_ready,
        input  o_ready, o_ct, o_valid
    );
endinterface

// File: rtl/simon_key_sched.sv
// On-the-fly Simon key schedule: M-word key register, z-sequence selection, optional key cache.
// Defining SIMON_KEY_CACHE_EN adds a master-key cache reloaded by key_valid_i while idle.
module simon_key_sched
    import simon_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int ZSEQ = 0,
    parameter int RW   = 6
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           idle_i,
    input  logic [RW-1:0]  round_i,
    input  logic [M*N-1:0] key_i,
    input  logic           key_valid_i,
    output logic [N-1:0]   k0_o
);
    localparam logic [61:0]  ZBITS   = zConst(ZSEQ);
    localparam logic [N-1:0] C_CONST = {{(N-2){1'b1}}, 2'b00};

    logic [N-1:0]   kreg_q [M];
    logic [N-1:0]   kreg_d [M];
    logic [M*N-1:0] loadKey;
    logic [N-1:0]   tmp;
    logic [N-1:0]   newTop;
    logic [5:0]     zIdx;
    logic           zBit;

`ifdef SIMON_KEY_CACHE_EN
    logic [M*N-1:0] cache_q;
    logic [M*N-1:0] cache_d;

    always_comb begin
        cache_d = cache_q;
        if (idle_i && key_valid_i) cache_d = key_i;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cache_q <= '0;
        else       cache_q <= cache_d;
    end

    // A key strobed together with the block bypasses the cache so it takes effect immediately.
    assign loadKey = key_valid_i ? key_i : cache_q;
`else
    logic unusedCacheCtl;
    assign unusedCacheCtl = idle_i ^ key_valid_i;
    assign loadKey        = key_i;
`endif

    assign zIdx = 6'(32'(round_i) % 32'd62);
    assign zBit = ZBITS[zIdx];

    always_comb begin
        tmp = N'(ror(32'(kreg_q[M-1]), 3, N));
        if (M == 4) tmp = tmp ^ kreg_q[1];
        newTop = C_CONST ^ N'(zBit) ^ kreg_q[0] ^ tmp ^ N'(ror(32'(tmp), 1, N));
        for (int j = 0; j < M; j++) kreg_d[j] = kreg_q[j];
        if (load_i) begin
            for (int j = 0; j < M; j++) kreg_d[j] = loadKey[j*N +: N];
        end else if (step_i) begin
            for (int j = 0; j < M - 1; j++) kreg_d[j] = kreg_q[j+1];
            kreg_d[M-1] = newTop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) kreg_q <= '{default: '0};
        else       kreg_q <= kreg_d;
    end

    assign k0_o = kreg_q[0];

endmodule

// File: rtl/simon_core_param.sv
// Parametrised Simon 2N/MN encryption core: one round per clock, key schedule generated alongside.
// Optional master-key cache (inside simon_key_sched) is enabled by defining SIMON_KEY_CACHE_EN.
module simon_core_param
    import simon_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int T    = 32,
    parameter int ZSEQ = 0
) (
    input logic               i_clk,
    input logic               i_rst,
    simon_core_param_if.slave bus
);
    localparam int            RW         = $clog2(T + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(T - 1);

    generate
        if (!cfgLegal(N, M, ZSEQ, T)) begin : g_cfg_error
            $error("simon_core_param: unsupported N=%0d M=%0d ZSEQ=%0d T=%0d", N, M, ZSEQ, T);
        end
    endgenerate

    simon_state_e  state_q;
    simon_state_e  state_d;
    logic [N-1:0]  x_q;
    logic [N-1:0]  x_d;
    logic [N-1:0]  y_q;
    logic [N-1:0]  y_d;
    logic [RW-1:0] round_q;
    logic [RW-1:0] round_d;
    logic [N-1:0]  roundKey;
    logic          accept;
    logic          stepRound;

    assign accept    = (state_q == ST_IDLE) && bus.i_valid;
    assign stepRound = (state_q == ST_RUN);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.i_valid) state_d = ST_RUN;
            ST_RUN:  if (round_q == LAST_ROUND) state_d = ST_DONE;
            ST_DONE: if (bus.i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Data words only move on acceptance or a round, so o_ct stays frozen through DONE and IDLE.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        round_d = round_q;
        if (accept) begin
            x_d     = bus.i_pt[2*N-1:N];
            y_d     = bus.i_pt[N-1:0];
            round_d = '0;
        end else if (stepRound) begin
            x_d     = y_q ^ N'(simon_f(32'(x_q), N)) ^ roundKey;
            y_d     = x_q;
            round_d = round_q + RW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            round_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            round_q <= round_d;
        end
    end

    simon_key_sched #(
        .N    (N),
        .M    (M),
        .ZSEQ (ZSEQ),
        .RW   (RW)
    ) u_key_sched (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .load_i      (accept),
        .step_i      (stepRound),
        .idle_i      (state_q == ST_IDLE),
        .round_i     (round_q),
        .key_i       (bus.i_key),
        .key_valid_i (bus.i_key_valid),
        .k0_o        (roundKey)
    );

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_valid = (state_q == ST_DONE);
    assign bus.o_ct    = {x_q, y_q};

endmodule

// File: tb/tb_simon_core_param.sv
// Directed bench for simon_core_param at the Simon32/64 and Simon64/128 design points.
// Cache sequences are added when SIMON_KEY_CACHE_EN is defined.
module tb_simon_core_param;

    localparam logic [63:0]  KEY16 = 64'h1918_1110_0908_0100;
    localparam logic [31:0]  PT16  = 32'h6565_6877;
    localparam logic [31:0]  CT16  = 32'hc69b_e9bb;
    localparam logic [127:0] KEY32 = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  PT32  = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT32  = 64'h44c8fc20_b9dfa07a;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    simon_core_param_if #(.N(16), .M(4)) bus16 ();
    simon_core_param_if #(.N(32), .M(4)) bus32 ();

    simon_core_param #(.N(16), .M(4), .T(32), .ZSEQ(0)) dut16 (
        .i_clk (clock),
        .i_rst (reset),
        .bus   (bus16)
    );

    simon_core_param #(.N(32), .M(4), .T(44), .ZSEQ(3)) dut32 (
        .i_clk (clock),
        .i_rst (reset),
        .bus   (bus32)
    );

`ifdef SIMON_KEY_CACHE_EN
    localparam logic [61:0] Z0_SEQ = 62'b11111010001001010110000111001101111101000100101011000011100110;

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    // Textbook Simon32/64 written from the published key expansion (~k ^ 3 form).
    function automatic logic [31:0] simon3264Model(input logic [63:0] key, input logic [31:0] pt);
        logic [15:0] k [32];
        logic [15:0] tmp;
        logic [15:0] x;
        logic [15:0] y;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = rotl16(k[i-1], 13);
            tmp  = tmp ^ k[i-3];
            tmp  = tmp ^ rotl16(tmp, 15);
            k[i] = ~k[i-4] ^ tmp ^ {15'd0, Z0_SEQ[61-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ (rotl16(x, 1) & rotl16(x, 8)) ^ rotl16(x, 2) ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction
`endif

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic readyOf(input bit wide);
        return wide ? bus32.o_ready : bus16.o_ready;
    endfunction

    function automatic logic validOf(input bit wide);
        return wide ? bus32.o_valid : bus16.o_valid;
    endfunction

    // Presents one block and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input bit wide, input logic [127:0] key, input logic [63:0] pt,
                                 input logic keyValid);
        int guard = 0;
        @(posedge clock); #1;
        if (wide) begin
            bus32.i_key       = key;
            bus32.i_pt        = pt;
            bus32.i_key_valid = keyValid;
            bus32.i_valid     = 1'b1;
        end else begin
            bus16.i_key       = key[63:0];
            bus16.i_pt        = pt[31:0];
            bus16.i_key_valid = keyValid;
            bus16.i_valid     = 1'b1;
        end
        while (!readyOf(wide) && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput("ready_before_accept", readyOf(wide), 1'b1);
        @(posedge clock); #1;
        bus32.i_valid     = 1'b0;
        bus32.i_key_valid = 1'b0;
        bus16.i_valid     = 1'b0;
        bus16.i_key_valid = 1'b0;
    endtask

    task automatic waitForValid(input bit wide, output int cycles);
        cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock); #1;
            if (validOf(wide)) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int pulses;

        bus16.i_key = '0; bus16.i_key_valid = 1'b0; bus16.i_pt = '0; bus16.i_valid = 1'b0; bus16.i_ready = 1'b1;
        bus32.i_key = '0; bus32.i_key_valid = 1'b0; bus32.i_pt = '0; bus32.i_valid = 1'b0; bus32.i_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("rst_ready16", bus16.o_ready, 1'b1);
        checkOutput("rst_valid16", bus16.o_valid, 1'b0);
        checkOutput("rst_ct16",    bus16.o_ct,    32'h0);
        checkOutput("rst_ready32", bus32.o_ready, 1'b1);
        checkOutput("rst_valid32", bus32.o_valid, 1'b0);
        checkOutput("rst_ct32",    bus32.o_ct,    64'h0);

`ifdef SIMON_KEY_CACHE_EN
        $display("[TB] cache: block before any key load uses the all-zero key");
        applyStimulus(1'b0, {64'h0, KEY16}, 64'h0, 1'b0);
        waitForValid(1'b0, cyc);
        checkOutput("cache_zero_key_ct", bus16.o_ct, simon3264Model(64'h0, 32'h0));
        @(posedge clock); #1;
        bus16.i_key = KEY16;
        bus16.i_key_valid = 1'b1;
        @(posedge clock); #1;
        bus16.i_key_valid = 1'b0;
        bus16.i_key = '0;
        for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b0, 128'h0, {32'h0, PT16}, 1'b0);
            waitForValid(1'b0, cyc);
            checkOutput("cache_b2b_ct", bus16.o_ct, CT16);
        end
`endif

        $display("[TB] Simon32/64 vector and latency");
        applyStimulus(1'b0, {64'h0, KEY16}, {32'h0, PT16}, 1'b1);
        checkOutput("run_ready16", bus16.o_ready, 1'b0);
        waitForValid(1'b0, cyc);
        checkOutput("latency16", cyc, 32);
        checkOutput("ct16", bus16.o_ct, CT16);
        @(posedge clock); #1;
        checkOutput("post_hs_valid16", bus16.o_valid, 1'b0);
        checkOutput("post_hs_ready16", bus16.o_ready, 1'b1);

        $display("[TB] Simon64/128 vector and latency");
        applyStimulus(1'b1, KEY32, PT32, 1'b1);
        waitForValid(1'b1, cyc);
        checkOutput("latency32", cyc, 44);
        checkOutput("ct32", bus32.o_ct, CT32);
        @(posedge clock); #1;
        checkOutput("post_hs_valid32", bus32.o_valid, 1'b0);

        $display("[TB] backpressure in DONE");
        bus16.i_ready = 1'b0;
        applyStimulus(1'b0, {64'h0, KEY16}, {32'h0, PT16}, 1'b1);
        waitForValid(1'b0, cyc);
        checkOutput("bp_latency", cyc, 32);
        bus16.i_key   = KEY16;
        bus16.i_pt    = PT16;
        bus16.i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            checkOutput("bp_valid", bus16.o_valid, 1'b1);
            checkOutput("bp_ready", bus16.o_ready, 1'b0);
            checkOutput("bp_ct",    bus16.o_ct,    CT16);
        end
        bus16.i_ready = 1'b1;
        @(posedge clock); #1;
        checkOutput("bp_release_valid", bus16.o_valid, 1'b0);
        checkOutput("bp_release_ready", bus16.o_ready, 1'b1);
        @(posedge clock); #1;
        bus16.i_valid = 1'b0;
        checkOutput("bp_second_accepted", bus16.o_ready, 1'b0);
        waitForValid(1'b0, cyc);
        checkOutput("bp_second_latency", cyc, 32);
        checkOutput("bp_second_ct", bus16.o_ct, CT16);

        $display("[TB] reset in the middle of RUN");
        applyStimulus(1'b0, {64'h0, KEY16}, {32'h0, PT16}, 1'b1);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("abort_ready", bus16.o_ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus16.o_valid) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);
        applyStimulus(1'b0, {64'h0, KEY16}, {32'h0, PT16}, 1'b1);
        waitForValid(1'b0, cyc);
        checkOutput("abort_next_latency", cyc, 32);
        checkOutput("abort_next_ct", bus16.o_ct, CT16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
